// File: rtl/ps2_move_scheduler.sv
// ps2_move_scheduler: turns a raw PS/2 Set-2 byte stream into move events.
// A small parser strips the E0/F0 prefixes and tracks five held game keys.
// Each new key-down schedules an immediate move. While any key is held, an
// auto-repeat timer re-arms every held key. A round-robin arbiter shares the
// single registered move output among the five keys.
//
// Handshake: move_valid/move_code form a registered source. Once move_valid
// is high, move_code stays stable until the cycle in which move_ready is
// high, which is the transfer. A new event may be loaded in that same cycle,
// so back-to-back transfers give one event per clock.
module ps2_move_scheduler #(
  parameter int REPEAT_DELAY   = 25_000_000,
  parameter int REPEAT_PERIOD  = 5_000_000,
  parameter int PREFIX_TIMEOUT = 100_000,
  parameter int CNT_W          = 25
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [2:0] move_code,
  output logic [4:0] held_keys,
  output logic       unknown_key
);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] PTO_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_EXT     = 2'd1,
    P_BRK     = 2'd2,
    P_EXT_BRK = 2'd3
  } pstate_t;

  // Internal reset: asserts together with resetn, releases on a clock edge
  logic [1:0] rst_sync;
  logic       rst_n;

  pstate_t          state_q, state_d;
  logic [CNT_W-1:0] pto_q, pto_d;
  logic             is_make, is_break, is_ext;
  logic [4:0]       key_hit;
  logic [4:0]       held_q, held_d;
  logic [4:0]       new_keys;
  logic [4:0]       pending_q, pending_d;
  logic [4:0]       set_mask, clr_mask;
  logic             unknown_q;
  logic [CNT_W-1:0] rep_cnt_q;
  logic             rep_phase_q;   // 0: waiting for first repeat, 1: periodic
  logic             rep_expire;
  logic [2:0]       rr_ptr_q;
  logic             move_valid_q;
  logic [2:0]       move_code_q;
  logic             load;
  logic             grant_found;
  logic [2:0]       grant_idx;
  logic [3:0]       scan;

  // Reset synchronizer: async assert, release after two rising edges
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Parser state and prefix-timeout counter
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= P_IDLE;
      pto_q   <= '0;
    end else begin
      state_q <= state_d;
      pto_q   <= pto_d;
    end
  end

  // Parser next state: classify each byte as prefix, make or break
  always_comb begin
    state_d  = state_q;
    pto_d    = '0;
    is_make  = 1'b0;
    is_break = 1'b0;
    is_ext   = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        P_IDLE: begin
          if (rx_data == 8'hE0)      state_d = P_EXT;
          else if (rx_data == 8'hF0) state_d = P_BRK;
          else                       is_make = 1'b1;
        end
        P_EXT: begin
          if (rx_data == 8'hF0)      state_d = P_EXT_BRK;
          else if (rx_data == 8'hE0) state_d = P_EXT;
          else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = P_IDLE;
          end
        end
        P_BRK: begin
          is_break = 1'b1;
          state_d  = P_IDLE;
        end
        default: begin
          is_break = 1'b1;
          is_ext   = 1'b1;
          state_d  = P_IDLE;
        end
      endcase
    end else if (state_q != P_IDLE) begin
      // A prefix left dangling too long is dropped
      if (pto_q == PTO_LAST) state_d = P_IDLE;
      else                   pto_d   = pto_q + CNT_W'(1);
    end
  end

  // Key map: final byte plus extended flag to a one-hot game key
  always_comb begin
    key_hit = '0;
    case ({is_ext, rx_data})
      9'h16B:  key_hit = 5'b00001;
      9'h174:  key_hit = 5'b00010;
      9'h175:  key_hit = 5'b00100;
      9'h172:  key_hit = 5'b01000;
      9'h029:  key_hit = 5'b10000;
      default: key_hit = 5'b00000;
    endcase
  end

  // Held-key bookkeeping; typematic makes of a held key change nothing
  always_comb begin
    new_keys = is_make ? (key_hit & ~held_q) : 5'b0;
    held_d   = held_q;
    if (is_make)  held_d = held_q | key_hit;
    if (is_break) held_d = held_q & ~key_hit;
  end

  assign rep_expire = (held_q != 5'b0) &&
                      (rep_cnt_q == (rep_phase_q ? PER_LAST : DLY_LAST));

  // Held keys, unknown-key pulse and the auto-repeat timer
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      held_q      <= '0;
      unknown_q   <= 1'b0;
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      held_q    <= held_d;
      unknown_q <= is_make && (key_hit == 5'b0);
      if (new_keys != 5'b0 || held_q == 5'b0) begin
        rep_cnt_q   <= '0;
        rep_phase_q <= 1'b0;
      end else if (rep_expire) begin
        rep_cnt_q   <= '0;
        rep_phase_q <= 1'b1;
      end else begin
        rep_cnt_q <= rep_cnt_q + CNT_W'(1);
      end
    end
  end

  // Round-robin search: first pending key at or above the pointer, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    scan        = 4'd0;
    for (int i = 0; i < 5; i++) begin
      scan = {1'b0, rr_ptr_q} + 4'(i);
      if (scan > 4'd4) scan = scan - 4'd5;
      if (!grant_found && pending_q[scan[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[2:0];
      end
    end
  end

  // Pending update: a set in the same cycle as the grant keeps the bit
  always_comb begin
    load      = !move_valid_q || move_ready;
    clr_mask  = (load && grant_found) ? (5'b00001 << grant_idx) : 5'b0;
    set_mask  = new_keys | (rep_expire ? held_q : 5'b0);
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  // Pending register and the registered output stage
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      rr_ptr_q     <= 3'd0;
      move_valid_q <= 1'b0;
      move_code_q  <= 3'd0;
    end else begin
      pending_q <= pending_d;
      if (load) begin
        if (grant_found) begin
          move_valid_q <= 1'b1;
          move_code_q  <= grant_idx + 3'd1;
          rr_ptr_q     <= (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
        end else begin
          move_valid_q <= 1'b0;
          move_code_q  <= 3'd0;
        end
      end
    end
  end

  assign move_valid  = move_valid_q;
  assign move_code   = move_code_q;
  assign held_keys   = held_q;
  assign unknown_key = unknown_q;

endmodule

// File: tb/tb_ps2_move_scheduler.sv
// tb_ps2_move_scheduler: scoreboard bench. Drivers send PS/2 byte sequences
// per game key; expected move codes (and, when the consumer is always ready,
// their exact arrival cycle) are queued; a negedge monitor pops and compares
// on every transfer and checks held_keys against the key model each cycle.
module tb_ps2_move_scheduler;

  localparam int RD = 20;
  localparam int RP = 8;
  localparam int PT = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       move_ready;
  logic       move_valid;
  logic [2:0] move_code;
  logic [4:0] held_keys;
  logic       unknown_key;

  ps2_move_scheduler #(
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .PREFIX_TIMEOUT(PT),
    .CNT_W         (25)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .move_ready  (move_ready),
    .move_valid  (move_valid),
    .move_code   (move_code),
    .held_keys   (held_keys),
    .unknown_key (unknown_key)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int         n_checks = 0;
  int         n_fail = 0;
  logic [2:0] exp_q[$];
  int         exp_t_q[$];
  logic [4:0] exp_held = 5'b0;
  int         exp_unk = 0;
  int         n_unk = 0;
  int         n_xfer = 0;
  int         rep_base = 0;
  int         last_tick = 0;
  bit         timed = 1'b0;
  bit         auto_push = 1'b1;
  bit         rand_ready = 1'b0;
  bit         ready_force = 1'b1;
  bit         prev_stall = 1'b0;
  int         prev_code = 0;
  int         mon_code;
  int         mon_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int code, input int t);
    exp_q.push_back(3'(code));
    exp_t_q.push_back(t);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One rx_done_tick strobe; returns just after the edge that consumed it
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data      = b;
    rx_done_tick = 1'b1;
    last_tick    = cyc;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
  endtask

  // Keys 0..4 are left,right,up,down,fire; 5..8 are unmapped look-alikes
  task automatic send_key(input int k, input bit brk);
    logic [7:0] sc;
    bit         ext;
    case (k)
      0:       begin sc = 8'h6B; ext = 1'b1; end
      1:       begin sc = 8'h74; ext = 1'b1; end
      2:       begin sc = 8'h75; ext = 1'b1; end
      3:       begin sc = 8'h72; ext = 1'b1; end
      4:       begin sc = 8'h29; ext = 1'b0; end
      5:       begin sc = 8'h6B; ext = 1'b0; end
      6:       begin sc = 8'h29; ext = 1'b1; end
      7:       begin sc = 8'h1C; ext = 1'b0; end
      default: begin sc = 8'h11; ext = 1'b1; end
    endcase
    if (ext) send_byte(8'hE0);
    if (brk) send_byte(8'hF0);
    send_byte(sc);
    if (k < 5) begin
      if (!brk && !exp_held[k]) begin
        rep_base = last_tick;
        if (auto_push) push(k + 1, timed ? last_tick + 2 : -1);
      end
      exp_held[k] = !brk;
    end else if (!brk) begin
      exp_unk++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      step(1);
      t++;
    end
    chk("drain_empty", exp_q.size(), 0);
    exp_q.delete();
    exp_t_q.delete();
  endtask

  // Consumer ready: forced level, or random with low runs of at most two cycles
  initial begin
    int low_run;
    low_run    = 0;
    move_ready = 1'b1;
    forever begin
      @(posedge clk);
      #3;
      if (rand_ready) begin
        if (low_run >= 2 || $urandom_range(0, 2) != 0) begin
          move_ready = 1'b1;
          low_run    = 0;
        end else begin
          move_ready = 1'b0;
          low_run++;
        end
      end else begin
        move_ready = ready_force;
      end
    end
  end

  // Auto-repeat model: every held key re-fires DELAY cycles after the last
  // new key-down, then every PERIOD cycles, as long as something is held
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (resetn && exp_held != 5'b0 && (cyc - rep_base) >= RD &&
          ((cyc - rep_base - RD) % RP) == 0) begin
        for (int i = 0; i < 5; i++)
          if (exp_held[i]) push(i + 1, timed ? cyc + 2 : -1);
      end
    end
  end

  // Monitor: compare outputs against the model away from the active edge
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_valid", move_valid, 0);
      chk("rst_code", move_code, 0);
      chk("rst_held", held_keys, 0);
      prev_stall = 1'b0;
    end else begin
      chk("held_keys", held_keys, exp_held);
      if (unknown_key) n_unk++;
      if (!move_valid) chk("idle_code", move_code, 0);
      if (prev_stall && move_valid) chk("stall_code", move_code, prev_code);
      if (move_valid && move_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_xfer: got code %0d expected none at cycle %0d",
                   move_code, cyc);
        end else begin
          mon_code = int'(exp_q.pop_front());
          mon_t    = exp_t_q.pop_front();
          chk("xfer_code", move_code, mon_code);
          if (mon_t >= 0) chk("xfer_time", cyc, mon_t);
        end
      end
      prev_stall = move_valid && !move_ready;
      prev_code  = move_code;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int n0;
    int cm;
    int cb;
    int s;
    int n_exp;
    int k;
    int hold;

    // Reset state
    step(3);
    chk("reset_valid", move_valid, 0);
    chk("reset_held", held_keys, 0);
    chk("reset_unknown", unknown_key, 0);
    resetn = 1'b1;
    step(4);

    // Up held: immediate event at +2, repeats at +20/+28/+36 after it
    timed       = 1'b1;
    ready_force = 1'b1;
    step(2);
    x0 = n_xfer;
    send_key(2, 1'b0);
    cm = last_tick;
    while (cyc < cm + 37) step(1);
    send_key(2, 1'b1);
    step(30);
    chk("up_hold_events", n_xfer - x0, 4);

    // Fire tap under backpressure: stable code, exactly one transfer
    timed       = 1'b0;
    ready_force = 1'b0;
    step(2);
    send_key(4, 1'b0);
    send_key(4, 1'b1);
    step(10);
    chk("bp_stalled_valid", move_valid, 1);
    x0          = n_xfer;
    ready_force = 1'b1;
    step(6);
    chk("bp_one_xfer", n_xfer - x0, 1);
    drain();

    // Unmapped makes and a timed-out E0 prefix
    n0 = n_unk;
    send_key(5, 1'b0);
    step(3);
    chk("unk_plain_6b", n_unk - n0, 1);
    send_byte(8'hE0);
    step(15);
    send_byte(8'h6B);
    exp_unk++;
    step(3);
    chk("unk_prefix_timeout", n_unk - n0, 2);
    send_key(6, 1'b0);
    send_key(6, 1'b1);
    step(3);
    chk("unk_e0_29", n_unk - n0, 3);
    chk("unk_no_valid", move_valid, 0);

    // Left, up, fire pending behind a stall: 1,3,5 on consecutive cycles
    auto_push   = 1'b0;
    ready_force = 1'b0;
    step(2);
    send_key(0, 1'b0);
    send_key(2, 1'b0);
    send_key(4, 1'b0);
    send_key(4, 1'b1);
    send_key(0, 1'b1);
    send_key(2, 1'b1);
    s = cyc;
    push(1, s);
    push(3, s + 1);
    push(5, s + 2);
    ready_force = 1'b1;
    step(6);
    drain();

    // Pointer wraps: up first, then fire and left -> 3,5,1
    ready_force = 1'b0;
    step(2);
    send_key(2, 1'b0);
    send_key(0, 1'b0);
    send_key(4, 1'b0);
    send_key(4, 1'b1);
    send_key(2, 1'b1);
    send_key(0, 1'b1);
    s = cyc;
    push(3, s);
    push(5, s + 1);
    push(1, s + 2);
    ready_force = 1'b1;
    step(6);
    drain();
    auto_push = 1'b1;

    // Typematic right: one immediate event, repeats timed from first make
    timed = 1'b1;
    step(3);
    x0 = n_xfer;
    send_key(1, 1'b0);
    cm = last_tick;
    for (int i = 0; i < 6; i++) begin
      step(1);
      send_key(1, 1'b0);
    end
    send_key(1, 1'b1);
    cb    = last_tick;
    n_exp = 1 + ((cb >= cm + RD) ? 1 + (cb - cm - RD) / RP : 0);
    step(30);
    chk("typematic_events", n_xfer - x0, n_exp);
    drain();

    // Reset while an event is stalled and a key is held
    timed       = 1'b0;
    ready_force = 1'b0;
    step(2);
    send_key(2, 1'b0);
    step(3);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", move_valid, 0);
    chk("async_rst_code", move_code, 0);
    chk("async_rst_held", held_keys, 0);
    exp_q.delete();
    exp_t_q.delete();
    exp_held    = 5'b0;
    ready_force = 1'b1;
    step(3);
    resetn = 1'b1;
    step(30);
    timed = 1'b1;
    x0    = n_xfer;
    send_key(0, 1'b0);
    send_key(0, 1'b1);
    step(5);
    chk("post_reset_fresh", n_xfer - x0, 1);
    drain();

    // Random key traffic with a random consumer
    timed      = 1'b0;
    rand_ready = 1'b1;
    for (int it = 0; it < 30; it++) begin
      k    = $urandom_range(0, 8);
      hold = $urandom_range(0, 45);
      send_key(k, 1'b0);
      cm = last_tick;
      while (cyc < cm + hold) begin
        if ($urandom_range(0, 5) == 0) send_key(k, 1'b0);
        else                           step(1);
      end
      send_key(k, 1'b1);
      drain();
      step(3);
    end
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    step(5);
    drain();
    chk("unknown_count", n_unk, exp_unk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
